// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
// Frame format, bit timing and the FSM state encoding live here so the
// transmitter, its FIFO and any bench agree on one definition.
package uart_pkg;

    localparam int DATA_W        = 8;
    localparam int BIT_IDX_W     = $clog2(DATA_W);
    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_CNT_W    = $clog2(TICKS_PER_BIT);

    localparam logic                  UART_IDLE_LEVEL = 1'b1;
    localparam logic [TICK_CNT_W-1:0] TICK_LAST       = TICK_CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0]  BIT_LAST        = BIT_IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Even parity over one data byte: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte write port of the UART transmitter.
// The bus side (master) offers a byte with TXVALID/TXDATA; the transmitter
// (slave) accepts it on the edge where TXVALID & TXREADY.
interface uart_tx_if;
    import uart_pkg::*;

    logic              TXVALID;
    logic [DATA_W-1:0] TXDATA;
    logic              TXREADY;

    modport master (output TXVALID, output TXDATA, input TXREADY);
    modport slave  (input TXVALID, input TXDATA, output TXREADY);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO for the UART transmitter.
// Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the occupancy count
// is one bit wider. full/empty come from the registered count only, so a pop
// in the same cycle never frees room for a push while full. count_next_o
// exposes the count that will be registered at the coming edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_next_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s, do_pop_s;

    assign full_o       = (count_q == CW'(FIFO_DEPTH));
    assign empty_o      = (count_q == '0);
    assign do_push_s    = push_i & ~full_o;
    assign do_pop_s     = pop_i & ~empty_o;
    assign head_o       = mem_q[rd_ptr_q];
    assign count_next_o = count_d;

    // Next pointer and occupancy values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // Pointer and count registers, emptied asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because count qualifies them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 8N1 frames, LSB first.
// Bytes written through the uart_tx_if slave port are queued in uart_tx_fifo
// and serialised on TXD; every bit lasts TICKS_PER_BIT BAUDTICK pulses.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after D7. TXD and BUSY are registered and are computed from next-state
// values so they change on the same edge as the FSM.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RESETn,
    input  logic      BAUDTICK,
    uart_tx_if.slave  tx_if,
    output logic      TXD,
    output logic      BUSY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e              state_q, state_d;
    logic [TICK_CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   bit_end_s;
    logic                   fifo_pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [DATA_W-1:0]      fifo_head_s;
    logic [CW-1:0]          fifo_count_next_s;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (CLK),
        .rst_n        (RESETn),
        .push_i       (tx_if.TXVALID),
        .push_data_i  (tx_if.TXDATA),
        .pop_i        (fifo_pop_s),
        .head_o       (fifo_head_s),
        .full_o       (fifo_full_s),
        .empty_o      (fifo_empty_s),
        .count_next_o (fifo_count_next_s)
    );

    assign tx_if.TXREADY = ~fifo_full_s;
    assign bit_end_s     = BAUDTICK & (tick_cnt_q == TICK_LAST);
    assign TXD           = txd_q;
    assign BUSY          = busy_q;

    // Frame sequencing: pop in IDLE, advance one bit per bit end, drive TXD/BUSY.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        fifo_pop_s = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        // The tick counter only runs while a frame is on the line.
        if ((state_q != TX_IDLE) && BAUDTICK) begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shreg_d    = fifo_head_s;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = even_parity(fifo_head_s);
`endif
                    state_d    = TX_START;
                end else begin
                    state_d    = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    state_d = TX_DATA;
                end else begin
                    state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    state_d = TX_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end_s) begin
                    state_d = TX_STOP;
                end else begin
                    state_d = TX_PARITY;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end_s) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_STOP;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Line level follows the state being entered, so TXD moves with the FSM.
        case (state_d)
            TX_IDLE:   txd_d = UART_IDLE_LEVEL;
            TX_START:  txd_d = ~UART_IDLE_LEVEL;
            TX_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: txd_d = parity_d;
`endif
            TX_STOP:   txd_d = UART_IDLE_LEVEL;
            default:   txd_d = UART_IDLE_LEVEL;
        endcase

        busy_d = (state_d != TX_IDLE) || (fifo_count_next_s != '0);
    end

    // FSM and datapath registers; reset forces the line idle at once.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= TX_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            txd_q      <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte currently being framed.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// A tick-domain serial monitor decodes TXD into rx_q; every accepted write
// pushes its byte to exp_q, and each scenario task drains both queues.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_CLKS   = 176;
    localparam int MON_STOP_IDX = 10;
`else
    localparam int FRAME_CLKS   = 160;
    localparam int MON_STOP_IDX = 9;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       start_bit;
        logic       par_bit;
        logic       stop_bit;
    } rx_t;

    logic CLK      = 1'b0;
    logic RESETn   = 1'b1;
    logic BAUDTICK = 1'b0;
    logic TXD;
    logic BUSY;

    uart_tx_if tx_if();

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .BAUDTICK (BAUDTICK),
        .tx_if    (tx_if),
        .TXD      (TXD),
        .BUSY     (BUSY)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 1;
    int div_cnt = 0;
    logic [7:0] exp_q[$];
    rx_t        rx_q[$];

    always #5 CLK = ~CLK;

    // BAUDTICK generator: one pulse every tick_div cycles, 0 disables.
    always @(posedge CLK) begin
        #2;
        if (tick_div == 0) begin
            BAUDTICK = 1'b0;
            div_cnt  = 0;
        end else begin
            BAUDTICK = (div_cnt == tick_div - 1);
            div_cnt  = (div_cnt >= tick_div - 1) ? 0 : div_cnt + 1;
        end
    end

    // Serial monitor: counts BAUDTICKs from the start edge, samples mid-bit.
    int   mon_ticks = 0;
    int   mon_idx = 0;
    bit   mon_active = 1'b0;
    logic [7:0] mon_data;
    logic mon_start, mon_par;
    always @(negedge CLK) begin
        if (!RESETn) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && TXD === 1'b0) begin
                mon_active = 1'b1;
                mon_ticks  = 0;
                mon_par    = 1'b0;
            end
            if (mon_active && BAUDTICK === 1'b1) begin
                mon_ticks++;
                if (mon_ticks % 16 == 8) begin
                    mon_idx = mon_ticks / 16;
                    if (mon_idx == 0) mon_start = TXD;
                    else if (mon_idx <= 8) mon_data[mon_idx-1] = TXD;
                    else if (mon_idx == MON_STOP_IDX) begin
                        rx_q.push_back('{mon_data, mon_start, mon_par, TXD});
                        $display("monitor: received 0x%02h", mon_data);
                        mon_active = 1'b0;
                    end else mon_par = TXD;
                end
            end
        end
    end

    // Present one byte until accepted; records it as expected output if asked.
    task automatic write_byte(input logic [7:0] b, input bit expect_out, output bit ok);
        int n = 0;
        ok = 1'b0;
        tx_if.TXVALID = 1'b1;
        tx_if.TXDATA  = b;
        while (!ok && n < 2000) begin
            ok = (tx_if.TXREADY === 1'b1);
            @(posedge CLK); #1;
            n++;
        end
        tx_if.TXVALID = 1'b0;
        if (ok && expect_out) exp_q.push_back(b);
    endtask

    // Wait (bounded) until BUSY is low.
    task automatic wait_idle(input int limit, output bit ok);
        int n = 0;
        while (BUSY !== 1'b0 && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        ok = (BUSY === 1'b0);
    endtask

    task automatic test_reset;
        RESETn = 1'b1;
        tx_if.TXVALID = 1'b0;
        tx_if.TXDATA  = 8'h00;
        tick_div = 1;
        #2 RESETn = 1'b0;
        repeat (3) @(posedge CLK); #1;
        n_cmp++; if (TXD !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", TXD); end
        n_cmp++; if (tx_if.TXREADY !== 1'b1) begin n_err++; $display("FAIL reset_txready: got %b want 1", tx_if.TXREADY); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        @(negedge CLK) RESETn = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if ({TXD, tx_if.TXREADY, BUSY} !== 3'b110) begin
                n_err++;
                $display("FAIL idle_outputs cycle %0d: TXD/TXREADY/BUSY got %b%b%b want 110", c, TXD, tx_if.TXREADY, BUSY);
            end
        end
    endtask

    task automatic test_single_byte;
        logic [10:0] frame;
        logic [7:0]  e;
        rx_t         r;
        bit          ok;
        tick_div = 1;
        repeat (2) @(posedge CLK); #1;
        frame = {2'b11, 8'h41, 1'b0};
`ifdef UART_TX_PARITY_EN
        frame[9] = ^8'h41;
`endif
        write_byte(8'h41, 1'b1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_accept: write of 0x41 not accepted"); end
        n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b want 1", BUSY); end
        for (int c = 1; c <= FRAME_CLKS + 1; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if (TXD !== ((c <= FRAME_CLKS) ? frame[(c-1)/16] : 1'b1)) begin
                n_err++; $display("FAIL single_txd cycle %0d: got %b want %b", c, TXD, (c <= FRAME_CLKS) ? frame[(c-1)/16] : 1'b1);
            end
            n_cmp++;
            if (BUSY !== (c <= FRAME_CLKS)) begin
                n_err++; $display("FAIL single_busy cycle %0d: got %b want %b", c, BUSY, (c <= FRAME_CLKS));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL single_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL single_rx: got 0x%02h start %b stop %b, want 0x%02h start 0 stop 1", r.data, r.start_bit, r.stop_bit, e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL single_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        rx_t        r;
        bit         ok1, ok2;
        logic       prev;
        int         c;
        tick_div = 1;
        write_byte(8'hFF, 1'b1, ok1);
        write_byte(8'hFF, 1'b1, ok2);
        n_cmp++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL b2b_accept: accepted %b%b want 11", ok1, ok2); end
        n_cmp++; if (TXD !== 1'b0) begin n_err++; $display("FAIL b2b_first_start: got %b want 0", TXD); end
        c = 0; prev = TXD;
        while (!(prev === 1'b1 && TXD === 1'b0) && c < 400) begin
            prev = TXD;
            @(posedge CLK); #1;
            c++;
        end
        n_cmp++; if (c != FRAME_CLKS + 1) begin n_err++; $display("FAIL b2b_gap: start-to-start %0d clk want %0d", c, FRAME_CLKS + 1); end
        wait_idle(1000, ok1);
        n_cmp++; if (!ok1) begin n_err++; $display("FAIL b2b_idle: BUSY still %b after bound, want 0", BUSY); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL b2b_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL b2b_rx: got 0x%02h stop %b, want 0x%02h stop 1", r.data, r.stop_bit, e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL b2b_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_hi_text;
        logic [7:0] msg [3];
        logic [7:0] e;
        rx_t        r;
        bit         ok;
        int         n, c;
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0D;
        tick_div = 3;
        for (int i = 0; i < 3; i++) begin
            write_byte(msg[i], 1'b1, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL hi_accept: byte %0d not accepted", i); end
        end
        // 'H' = 0x48: D0..D2 are 0 and D3 is 1, so the first high stretch is one bit.
        n = 0;
        while (TXD !== 1'b1 && n < 1000) begin @(posedge CLK); #1; n++; end
        c = 0;
        while (TXD === 1'b1 && c < 1000) begin @(posedge CLK); #1; c++; end
        n_cmp++; if (c != 48) begin n_err++; $display("FAIL hi_bit_len: bit lasted %0d clk want 48", c); end
        wait_idle(5000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL hi_idle: BUSY still %b after bound, want 0", BUSY); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL hi_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL hi_rx: got 0x%02h start %b stop %b, want 0x%02h start 0 stop 1", r.data, r.start_bit, r.stop_bit, e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL hi_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_full_boundary;
        logic [7:0] d, e;
        logic       rdy;
        rx_t        r;
        int         acc;
        bit         ok;
        tick_div = 0;
        repeat (2) @(posedge CLK); #1;
        acc = 0;
        tx_if.TXVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'h10 + 8'(i);
            tx_if.TXDATA = d;
            rdy = tx_if.TXREADY;
            n_cmp++; if (rdy !== (i < 5)) begin n_err++; $display("FAIL full_txready cycle %0d: got %b want %b", i + 1, rdy, (i < 5)); end
            @(posedge CLK); #1;
            if (rdy === 1'b1) begin acc++; exp_q.push_back(d); end
        end
        tx_if.TXVALID = 1'b0;
        n_cmp++; if (acc != 5) begin n_err++; $display("FAIL full_accepted: %0d bytes want 5", acc); end
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if ({TXD, tx_if.TXREADY, BUSY} !== 3'b001) begin
                n_err++; $display("FAIL full_frozen cycle %0d: TXD/TXREADY/BUSY got %b%b%b want 001", c, TXD, tx_if.TXREADY, BUSY);
            end
        end
        tick_div = 1;
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL full_idle: BUSY still %b after bound, want 0", BUSY); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL full_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL full_rx: got 0x%02h stop %b, want 0x%02h stop 1", r.data, r.stop_bit, e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL full_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] e;
        rx_t        r;
        bit         ok;
        tick_div = 1;
        write_byte(8'h55, 1'b0, ok);
        write_byte(8'h66, 1'b0, ok);
        write_byte(8'h77, 1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_accept: queued bytes not accepted"); end
        // 0x55 entered START one edge after its write; D3 spans frame cycles 65..80.
        repeat (68) @(posedge CLK);
        #3;
        n_cmp++; if (TXD !== 1'b0) begin n_err++; $display("FAIL mid_d3_level: got %b want 0", TXD); end
        RESETn = 1'b0;
        #1;
        n_cmp++; if (TXD !== 1'b1) begin n_err++; $display("FAIL mid_reset_txd: got %b want 1", TXD); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", BUSY); end
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (tx_if.TXREADY !== 1'b1) begin n_err++; $display("FAIL mid_txready: got %b want 1", tx_if.TXREADY); end
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if ({TXD, BUSY} !== 2'b10) begin n_err++; $display("FAIL mid_after_release cycle %0d: TXD/BUSY got %b%b want 10", c, TXD, BUSY); end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL mid_no_rx: %0d frames, want 0", rx_q.size()); rx_q.delete(); end
        write_byte(8'h0A, 1'b1, ok);
        wait_idle(1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_idle: BUSY still %b after bound, want 0", BUSY); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL mid_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL mid_rx: got 0x%02h start %b stop %b, want 0x%02h start 0 stop 1", r.data, r.start_bit, r.stop_bit, e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL mid_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] e;
        rx_t        r;
        bit         ok;
        tick_div = 1;
        write_byte(8'h07, 1'b1, ok);
        write_byte(8'h03, 1'b1, ok);
        wait_idle(1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL par_idle: BUSY still %b after bound, want 0", BUSY); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_err++; $display("FAIL par_rx: nothing received, want 0x%02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.par_bit !== ^e || r.stop_bit !== 1'b1) begin
                    n_err++; $display("FAIL par_rx: got 0x%02h par %b stop %b, want 0x%02h par %b stop 1", r.data, r.par_bit, r.stop_bit, e, ^e);
                end
            end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL par_rx_extra: %0d extra frames, want 0", rx_q.size()); rx_q.delete(); end
    endtask
`endif

    // Scenario sequence.
    initial begin
        tx_if.TXVALID = 1'b0;
        tx_if.TXDATA  = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_hi_text();
        test_full_boundary();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
